// File: rtl/key_entry_pkg.sv
// key_entry_pkg: FSM states, op codes, key classes and the 4x4 keypad position decoder
package key_entry_pkg;
  typedef enum logic [1:0] {S_A, S_B, S_DONE} state_t;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
  localparam logic [1:0] KEY_DIGIT = 2'd0, KEY_OP = 2'd1, KEY_CLEAR = 2'd2, KEY_ENTER = 2'd3;
  function automatic logic [5:0] key_map(input logic [3:0] pos);
    logic [1:0] r, c;
    {r, c} = pos;
    if (c == 2'd3) return {KEY_OP, 2'b00, r};
    if (r == 2'd3) return c == 2'd0 ? {KEY_CLEAR, 4'd0} : c == 2'd1 ? {KEY_DIGIT, 4'd0} : {KEY_ENTER, 4'd0};
    return {KEY_DIGIT, 4'({2'b00, r} * 4'd3 + {2'b00, c} + 4'd1)};
  endfunction
endpackage

// File: rtl/key_entry_ctrl_key_debounce.sv
// key_debounce: syncs key_pos/key_down, qualifies presses, holds until release; out key_stb pulse + key_code
module key_debounce #(
  parameter int PRESS_CYCLES   = 1024,
  parameter int RELEASE_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_pos,
  input  logic       key_down,
  output logic       key_stb,
  output logic [3:0] key_code
);
  localparam int PW = $clog2(PRESS_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  logic [3:0] pos_m, pos_s, pos_p;
  logic down_m, down_s, held;
  logic [PW-1:0] press_cnt;
  logic [RW-1:0] rel_cnt;
  logic qual, press_done, rel_run, rel_done;
  assign qual = down_s && !held && pos_s == pos_p;
  assign press_done = qual && press_cnt == PW'(PRESS_CYCLES - 1);
  assign rel_run = held && !down_s;
  assign rel_done = rel_run && rel_cnt == RW'(RELEASE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos_m <= '0;
      pos_s <= '0;
      pos_p <= '0;
      down_m <= 1'b0;
      down_s <= 1'b0;
      held <= 1'b0;
      press_cnt <= '0;
      rel_cnt <= '0;
      key_stb <= 1'b0;
      key_code <= '0;
    end else begin
      pos_m <= key_pos;
      pos_s <= pos_m;
      pos_p <= pos_s;
      down_m <= key_down;
      down_s <= down_m;
      key_stb <= press_done;
      press_cnt <= qual && !press_done ? press_cnt + 1'b1 : '0;
      rel_cnt <= rel_run && !rel_done ? rel_cnt + 1'b1 : '0;
      if (press_done) key_code <= pos_s;
      held <= press_done ? 1'b1 : rel_done ? 1'b0 : held;
    end
endmodule

// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: keypad strobes -> "A op B" operands; out valid/operand_a/operand_b/op_code (valid/ready), entry_value/digit_count/err/key_stb
module key_entry_ctrl
  import key_entry_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int MAX_DIGITS     = 4,
  parameter int PRESS_CYCLES   = 1024,
  parameter int RELEASE_CYCLES = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_pos,
  input  logic             key_down,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [1:0]       op_code,
  output logic [WIDTH-1:0] entry_value,
  output logic [2:0]       digit_count,
  output logic             err,
  output logic             key_stb
);
  state_t state;
  logic [WIDTH-1:0] acc;
  logic [3:0] key_code, kv;
  logic [1:0] kc;
  key_debounce #(.PRESS_CYCLES(PRESS_CYCLES), .RELEASE_CYCLES(RELEASE_CYCLES)) u_deb (
    .clk(clk), .rst_n(rst_n), .key_pos(key_pos), .key_down(key_down), .key_stb(key_stb), .key_code(key_code)
  );
  assign {kc, kv} = key_map(key_code);
  assign entry_value = acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || (key_stb && kc == KEY_CLEAR)) begin
      state <= S_A;
      acc <= '0;
      digit_count <= '0;
      operand_a <= '0;
      operand_b <= '0;
      op_code <= OP_ADD;
      err <= 1'b0;
      valid <= 1'b0;
    end else if (state == S_DONE) begin
      if (ready) begin
        valid <= 1'b0;
        acc <= '0;
        digit_count <= '0;
        err <= 1'b0;
        state <= S_A;
      end
    end else if (key_stb) begin
      if (kc == KEY_DIGIT) begin
        if (digit_count < 3'(MAX_DIGITS)) begin
          acc <= WIDTH'({4'b0000, acc} * (WIDTH + 4)'(10) + (WIDTH + 4)'(kv));
          digit_count <= digit_count + 1'b1;
        end else err <= 1'b1;
      end else if (kc == KEY_OP) begin
        if (state == S_A) begin
          operand_a <= acc;
          op_code <= kv[1:0];
          acc <= '0;
          digit_count <= '0;
          state <= S_B;
        end else if (digit_count == 3'd0) op_code <= kv[1:0];
      end else if (kc == KEY_ENTER && state == S_B) begin
        operand_b <= acc;
        valid <= 1'b1;
        state <= S_DONE;
      end
    end
endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb_key_entry_ctrl: directed self-checking bench for key_entry_ctrl
module tb_key_entry_ctrl;
  import key_entry_pkg::*;
  logic clk, rst_n, key_down, ready, valid, err, key_stb;
  logic [3:0] key_pos;
  logic [15:0] operand_a, operand_b, entry_value;
  logic [1:0] op_code;
  logic [2:0] digit_count;
  int errors = 0, checks = 0, stb_cnt = 0, base;
  key_entry_ctrl #(.WIDTH(16), .MAX_DIGITS(4), .PRESS_CYCLES(4), .RELEASE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .key_pos(key_pos), .key_down(key_down), .ready(ready), .valid(valid),
    .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code), .entry_value(entry_value),
    .digit_count(digit_count), .err(err), .key_stb(key_stb)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (key_stb) stb_cnt <= stb_cnt + 1;
  task automatic press(input logic [3:0] pos, input int hold, input int rel);
    key_pos = pos;
    key_down = 1'b1;
    repeat (hold) @(negedge clk);
    key_down = 1'b0;
    repeat (rel) @(negedge clk);
  endtask
  task automatic test_reset;
    #1;
    checks++; if ({valid, operand_a, operand_b, op_code, entry_value, digit_count, err, key_stb} !== '0) begin errors++; $display("FAIL reset_outputs got nonzero outputs, required all 0"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic_entry;
    base = stb_cnt;
    press(4'd0, 10, 20);
    press(4'd1, 10, 20);
    press(4'd3, 10, 20);
    press(4'd2, 10, 20);
    press(4'd14, 10, 20);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %0d required 1", valid); end
    checks++; if (operand_a !== 16'd12) begin errors++; $display("FAIL t1_operand_a got %0d required 12", operand_a); end
    checks++; if (op_code !== OP_ADD) begin errors++; $display("FAIL t1_op_code got %0d required 0", op_code); end
    checks++; if (operand_b !== 16'd3) begin errors++; $display("FAIL t1_operand_b got %0d required 3", operand_b); end
    checks++; if (stb_cnt - base !== 5) begin errors++; $display("FAIL t1_strobes got %0d required 5", stb_cnt - base); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t1_handshake_valid got %0d required 0", valid); end
    checks++; if (operand_a !== 16'd12) begin errors++; $display("FAIL t1_keep_a got %0d required 12", operand_a); end
  endtask
  task automatic test_bounce;
    base = stb_cnt;
    key_pos = 4'd5;
    key_down = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      key_down = 1'b0;
      @(negedge clk);
      key_down = 1'b1;
      repeat (3) @(negedge clk);
    end
    key_pos = 4'd6;
    repeat (10) @(negedge clk);
    key_down = 1'b0;
    repeat (10) @(negedge clk);
    key_down = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (stb_cnt - base !== 1) begin errors++; $display("FAIL t2_one_strobe got %0d required 1", stb_cnt - base); end
    key_down = 1'b0;
    repeat (20) @(negedge clk);
    press(4'd6, 10, 20);
    checks++; if (stb_cnt - base !== 2) begin errors++; $display("FAIL t2_after_release got %0d required 2", stb_cnt - base); end
    checks++; if (entry_value !== 16'd56) begin errors++; $display("FAIL t2_entry got %0d required 56", entry_value); end
    press(4'd12, 10, 20);
  endtask
  task automatic test_overflow_clear;
    for (int i = 0; i < 5; i++) press(4'd10, 10, 20);
    checks++; if (entry_value !== 16'd9999) begin errors++; $display("FAIL t3_entry got %0d required 9999", entry_value); end
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL t3_count got %0d required 4", digit_count); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL t3_err got %0d required 1", err); end
    press(4'd12, 10, 20);
    checks++; if ({entry_value, digit_count, err, valid, operand_a} !== '0) begin errors++; $display("FAIL t3_clear entry=%0d count=%0d err=%0d required all 0", entry_value, digit_count, err); end
    checks++; if (dut.state !== S_A) begin errors++; $display("FAIL t3_state got %0d required %0d", dut.state, S_A); end
  endtask
  task automatic test_op_replace_hold;
    press(4'd8, 10, 20);
    press(4'd7, 10, 20);
    press(4'd15, 10, 20);
    press(4'd1, 10, 20);
    press(4'd14, 10, 20);
    checks++; if (op_code !== OP_DIV) begin errors++; $display("FAIL t4_op_code got %0d required 3", op_code); end
    checks++; if (operand_a !== 16'd7) begin errors++; $display("FAIL t4_operand_a got %0d required 7", operand_a); end
    checks++; if (operand_b !== 16'd2) begin errors++; $display("FAIL t4_operand_b got %0d required 2", operand_b); end
    press(4'd0, 10, 20);
    repeat (20) @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t4_hold_valid got %0d required 1", valid); end
    checks++; if ({operand_a, operand_b, op_code} !== {16'd7, 16'd2, OP_DIV}) begin errors++; $display("FAIL t4_hold_operands a=%0d b=%0d op=%0d required 7 2 3", operand_a, operand_b, op_code); end
    checks++; if (entry_value !== 16'd2 || digit_count !== 3'd1) begin errors++; $display("FAIL t4_hold_entry got %0d/%0d required 2/1", entry_value, digit_count); end
  endtask
  task automatic test_handshake_collision;
    key_pos = 4'd5;
    key_down = 1'b1;
    for (int i = 0; i < 20 && !key_stb; i++) @(negedge clk);
    checks++; if (key_stb !== 1'b1) begin errors++; $display("FAIL t5_strobe_timeout got %0d required 1", key_stb); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t5_valid got %0d required 0", valid); end
    checks++; if (dut.state !== S_A) begin errors++; $display("FAIL t5_state got %0d required %0d", dut.state, S_A); end
    checks++; if (entry_value !== 16'd0 || digit_count !== 3'd0) begin errors++; $display("FAIL t5_entry got %0d/%0d required 0/0", entry_value, digit_count); end
    key_down = 1'b0;
    repeat (20) @(negedge clk);
  endtask
  task automatic test_async_reset;
    press(4'd4, 10, 20);
    press(4'd5, 10, 20);
    checks++; if (entry_value !== 16'd45) begin errors++; $display("FAIL t6_entry got %0d required 45", entry_value); end
    key_pos = 4'd9;
    key_down = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({valid, operand_a, operand_b, op_code, entry_value, digit_count, err, key_stb} !== '0) begin errors++; $display("FAIL t6_async_reset a=%0d op=%0d entry=%0d required all 0", operand_a, op_code, entry_value); end
    @(negedge clk);
    rst_n = 1'b1;
    base = stb_cnt;
    repeat (6) @(negedge clk);
    checks++; if (key_stb !== 1'b0) begin errors++; $display("FAIL t6_early_strobe got %0d required 0", key_stb); end
    @(negedge clk);
    checks++; if (key_stb !== 1'b1) begin errors++; $display("FAIL t6_requalify got %0d required 1", key_stb); end
    key_down = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (stb_cnt - base !== 1) begin errors++; $display("FAIL t6_strobes got %0d required 1", stb_cnt - base); end
    checks++; if (entry_value !== 16'd8) begin errors++; $display("FAIL t6_entry_after got %0d required 8", entry_value); end
  endtask
  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    key_pos = 4'd0;
    key_down = 1'b0;
    ready = 1'b0;
    test_reset();
    test_basic_entry();
    test_bounce();
    test_overflow_clear();
    test_op_replace_hold();
    test_handshake_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
